anti_theft_timer: RTL and testbench
===================================

Name: anti_theft_timer

Overview:
- Countdown timer serving the anti-theft FSM over its timer request/response interface: FSM issues start_timer plus interval select; this block answers with a one-cycle timer_status expiry pulse.
- Holds the four programmable delay parameters (arm delay, driver-door delay, passenger-door delay, alarm-on time) and a 1 Hz time base derived from the system clock.
- Also exports remaining time for the display.

Parameters:
- CLK_FREQ, 27000000, clock cycles per second; benches use 4.
- DEF_ARM, 6, reset value of T_ARM_DELAY in seconds.
- DEF_DRIVER, 8, reset value of T_DRIVER_DELAY in seconds.
- DEF_PASSENGER, 15, reset value of T_PASSENGER_DELAY in seconds.
- DEF_ALARM, 10, reset value of T_ALARM_ON in seconds.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_timer  in  1  one-cycle request: load and start countdown.
- interval  in  2  select sampled with start_timer: 0=ARM, 1=DRIVER, 2=PASSENGER, 3=ALARM.
- reprogram  in  1  write time_value into parameter[time_parameter_selector].
- time_parameter_selector  in  2  parameter index for reprogram, same encoding as interval.
- time_value  in  4  new parameter value in seconds (0..15).
- timer_status  out  1  one-cycle expiry pulse to the FSM.
- one_hz_enable  out  1  one-cycle tick each second while counting.
- time_remaining  out  4  seconds left; 0 when idle.
- busy  out  1  high while in COUNT.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; divider=0; time_remaining=0.
  - timer_status, one_hz_enable and busy all 0.
  - Parameters restored to DEF_* values.
- States:
  - IDLE: start_timer -> load time_remaining=param[interval], clear divider. Go to COUNT if the value is nonzero, else ZERO.
  - COUNT: divider counts 0..CLK_FREQ-1. When divider==CLK_FREQ-1: one_hz_enable=1 next cycle, divider wraps to 0, time_remaining decrements. Decrement from 1 to 0 asserts timer_status on that same edge and goes to IDLE.
  - ZERO: one-cycle state. timer_status=1 and return to IDLE.
- Latency:
  - start_timer sampled at edge E0 with value N>0: timer_status is high for exactly the cycle after edge E0+N*CLK_FREQ, then low.
  - N=0: timer_status is high the cycle after E0.
- one_hz_enable: never asserted in IDLE. Divider is held at 0 outside COUNT.
- busy=1 exactly while state==COUNT.
- timer_status:
  - Registered.
  - Never high for more than 1 consecutive cycle, except when a 0-value start arrives back-to-back.
- start_timer while in COUNT: restart. Reload from the new interval, clear divider, no timer_status for the aborted count.
- start_timer in the same cycle as the expiring tick: the restart wins and timer_status is not asserted.
- reprogram:
  - Takes effect on the next edge.
  - Does not change a countdown in progress; the value is latched at start.
  - reprogram and start_timer in the same cycle on the same index: start uses the old value.
- time_remaining is 4-bit unsigned and never wraps below 0.
- Async reset mid-count: immediate return to reset values, including parameters.

Test Plan:
- CLK_FREQ=4, reset released, start_timer with interval=0 -> busy=1; time_remaining 6,5,...,1 with one_hz_enable every 4 cycles; timer_status single pulse exactly 24 cycles after the start edge; busy=0 after.
- reprogram selector=2, value=3, then start interval=2 -> timer_status 12 cycles after start; other parameters still DEF values (start interval=1 expires at 32).
- reprogram selector=3, value=0, start interval=3 -> timer_status high the cycle after start, one_hz_enable never pulses, busy stays 0.
- Start interval=1 (8 s), at 10 cycles in restart with interval=0 -> no pulse for the first count; timer_status 24 cycles after the second start.
- During an ARM count, reprogram index 0 to 2 -> the current count still expires at 24 cycles; the next ARM start expires at 8.
- Drive reset=0 mid-count between clock edges -> outputs 0 immediately without a clock edge; parameters back to defaults; no stray timer_status after release.

Source files
------------

// File: rtl/anti_theft_timer.sv
// Countdown timer for the anti-theft FSM: holds four programmable delays,
// derives a 1 Hz tick from the system clock and answers each start with one expiry pulse.
module anti_theft_timer #(
  parameter int CLK_FREQ      = 27000000,
  parameter int DEF_ARM       = 6,
  parameter int DEF_DRIVER    = 8,
  parameter int DEF_PASSENGER = 15,
  parameter int DEF_ALARM     = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       reprogram,
  input  logic [1:0] time_parameter_selector,
  input  logic [3:0] time_value,
  output logic       timer_status,
  output logic       one_hz_enable,
  output logic [3:0] time_remaining,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int DIV_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_FREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_ZERO  = 2'd2
  } state_t;

  // Request/response: start_timer is a one-cycle request that is always
  // accepted (no ready); timer_status is the one-cycle registered response.
  // A new request aborts any count in progress without a response.
  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       rem_q, rem_d;
  logic             status_q, status_d;
  logic             hz_q, hz_d;
  logic [3:0]       param_q [4];
  logic [3:0]       load_val;

  assign load_val = param_q[interval];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      param_q[0] <= 4'(DEF_ARM);
      param_q[1] <= 4'(DEF_DRIVER);
      param_q[2] <= 4'(DEF_PASSENGER);
      param_q[3] <= 4'(DEF_ALARM);
    end else if (reprogram) begin
      param_q[time_parameter_selector] <= time_value;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      rem_q    <= 4'd0;
      status_q <= 1'b0;
      hz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      status_q <= status_d;
      hz_q     <= hz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    rem_d    = rem_q;
    status_d = 1'b0;
    hz_d     = 1'b0;
    if (start_timer) begin
      // A start in any state reloads; this also lets a restart beat an expiring tick.
      rem_d = load_val;
      div_d = '0;
      if (load_val != 4'd0) begin
        state_d = S_COUNT;
      end else begin
        state_d  = S_ZERO;
        status_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_COUNT: begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (rem_q <= 4'd1) begin
              // Final tick: report expiry instead of a 1 Hz tick so IDLE never sees one.
              rem_d    = 4'd0;
              state_d  = S_IDLE;
              status_d = 1'b1;
            end else begin
              rem_d = rem_q - 4'd1;
              hz_d  = 1'b1;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        S_ZERO: begin
          state_d = S_IDLE;
          div_d   = '0;
          rem_d   = 4'd0;
        end
        default: begin
          state_d = S_IDLE;
          div_d   = '0;
          rem_d   = 4'd0;
        end
      endcase
    end
  end

  assign timer_status   = status_q;
  assign one_hz_enable  = hz_q;
  assign time_remaining = rem_q;
  assign busy           = (state_q == S_COUNT);
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_anti_theft_timer.sv
// Bench for anti_theft_timer: a start-time/elapsed-cycles model predicts every
// output each cycle, and directed scenarios pin expiry latencies to literal values.
module tb_anti_theft_timer;

  localparam int CF = 4;

  logic       clock;
  logic       reset;
  logic       start_timer;
  logic [1:0] interval;
  logic       reprogram;
  logic [1:0] time_parameter_selector;
  logic [3:0] time_value;
  logic       timer_status;
  logic       one_hz_enable;
  logic [3:0] time_remaining;
  logic       busy;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  anti_theft_timer #(
    .CLK_FREQ(CF), .DEF_ARM(6), .DEF_DRIVER(8), .DEF_PASSENGER(15), .DEF_ALARM(10)
  ) dut (
    .clock(clock), .reset(reset), .start_timer(start_timer), .interval(interval),
    .reprogram(reprogram), .time_parameter_selector(time_parameter_selector),
    .time_value(time_value), .timer_status(timer_status), .one_hz_enable(one_hz_enable),
    .time_remaining(time_remaining), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: remember when the count began and from what value; outputs follow
  // from elapsed whole seconds, not from a divider/state machine.
  int         cyc = 0;
  int         start_edge = 0;
  int         n_ld = 0;
  bit         active = 0;
  int         m_param [4] = '{6, 8, 15, 10};
  logic       exp_status = 0, exp_hz = 0, exp_busy = 0;
  logic [3:0] exp_rem = 0;
  logic [31:0] exp_q[$];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      active = 0;
      m_param = '{6, 8, 15, 10};
      exp_status = 0; exp_hz = 0; exp_busy = 0; exp_rem = 0;
      exp_q.delete();
    end else begin
      int e, left;
      cyc++;
      if (start_timer) begin
        n_ld = m_param[interval];
        start_edge = cyc;
        active = 1;
      end
      if (reprogram) m_param[time_parameter_selector] = int'(time_value);
      exp_status = 0; exp_hz = 0; exp_busy = 0; exp_rem = 0;
      if (active) begin
        e = cyc - start_edge;
        left = n_ld - e / CF;
        if (left <= 0) begin
          exp_status = 1;
          active = 0;
          exp_q.push_back(32'(cyc));
        end else begin
          exp_busy = 1;
          exp_rem = 4'(left);
          exp_hz = (e > 0) && (e % CF == 0);
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clock) begin
    if (timer_status !== exp_status)
      $display("  state_dbg=%0d at status mismatch", state_dbg);
    check("timer_status", int'(timer_status), int'(exp_status));
    check("one_hz_enable", int'(one_hz_enable), int'(exp_hz));
    check("busy", int'(busy), int'(exp_busy));
    check("time_remaining", int'(time_remaining), int'(exp_rem));
    if (timer_status === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_pulse_cycle", cyc, -1);
      else check("pulse_cycle", cyc, int'(exp_q.pop_front()));
    end
  end

  // Driver tasks
  int t0 = 0;

  task automatic do_start(input logic [1:0] iv);
    @(negedge clock);
    start_timer = 1'b1; interval = iv;
    @(negedge clock);
    start_timer = 1'b0;
    t0 = cyc;
  endtask

  task automatic do_reprogram(input logic [1:0] sel, input logic [3:0] val);
    @(negedge clock);
    reprogram = 1'b1; time_parameter_selector = sel; time_value = val;
    @(negedge clock);
    reprogram = 1'b0;
  endtask

  task automatic wait_status(input string name, input int exp_lat);
    while (timer_status !== 1'b1 && (cyc - t0) < 200) @(negedge clock);
    check(name, cyc - t0, exp_lat);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; start_timer = 1'b0; interval = 2'd0;
    reprogram = 1'b0; time_parameter_selector = 2'd0; time_value = 4'd0;
    repeat (3) @(negedge clock);
    check("reset_status", int'(timer_status), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_rem", int'(time_remaining), 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // ARM default 6 s
    do_start(2'd0);
    check("arm_busy", int'(busy), 1);
    check("arm_rem_first", int'(time_remaining), 6);
    wait_status("arm_latency", 24);
    check("arm_busy_after", int'(busy), 0);

    // Reprogram PASSENGER to 3, others keep defaults
    do_reprogram(2'd2, 4'd3);
    do_start(2'd2);
    wait_status("pass3_latency", 12);
    do_start(2'd1);
    wait_status("driver_latency", 32);

    // ALARM 0: immediate pulse, never busy
    do_reprogram(2'd3, 4'd0);
    do_start(2'd3);
    check("zero_busy", int'(busy), 0);
    wait_status("zero_latency", 0);

    // Back-to-back zero starts
    @(negedge clock);
    start_timer = 1'b1; interval = 2'd3;
    repeat (2) @(negedge clock);
    start_timer = 1'b0;
    repeat (3) @(negedge clock);

    // Restart mid-count, first count gives no pulse
    do_start(2'd1);
    repeat (9) @(negedge clock);
    do_start(2'd0);
    wait_status("restart_latency", 24);

    // Reprogram ARM during ARM count
    do_start(2'd0);
    repeat (3) @(negedge clock);
    do_reprogram(2'd0, 4'd2);
    wait_status("arm_unchanged_latency", 24);
    do_start(2'd0);
    wait_status("arm2_latency", 8);

    // Restart on the expiring tick wins
    do_start(2'd2);
    while (cyc < t0 + 11) @(negedge clock);
    check("pre_expiry_rem", int'(time_remaining), 1);
    start_timer = 1'b1; interval = 2'd2;
    @(negedge clock);
    start_timer = 1'b0;
    t0 = cyc;
    check("restart_on_tick_no_pulse", int'(timer_status), 0);
    wait_status("restart_on_tick_latency", 12);

    // Reprogram and start same index same cycle: old value used
    @(negedge clock);
    reprogram = 1'b1; time_parameter_selector = 2'd2; time_value = 4'd5;
    start_timer = 1'b1; interval = 2'd2;
    @(negedge clock);
    reprogram = 1'b0; start_timer = 1'b0;
    t0 = cyc;
    wait_status("same_cycle_old_value", 12);
    do_start(2'd2);
    wait_status("same_cycle_new_value", 20);

    // Async reset mid-count, between edges
    do_start(2'd1);
    repeat (6) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("async_status", int'(timer_status), 0);
    check("async_busy", int'(busy), 0);
    check("async_rem", int'(time_remaining), 0);
    check("async_hz", int'(one_hz_enable), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    do_start(2'd2);
    wait_status("default_pass_latency", 60);
    do_start(2'd3);
    wait_status("default_alarm_latency", 40);

    repeat (3) @(negedge clock);
    check("pending_pulses", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
